// File: rtl/control_muestreo.sv
// Periodic ADC acquisition sequencer: requests conversions, registers valid samples,
// tracks consecutive out-of-range readings and flags conversion timeouts.
module control_muestreo #(
    parameter int PERIODO_MUESTREO = 1000,
    parameter int TIMEOUT          = 64,
    parameter int TEMP_BAJO        = 180,
    parameter int TEMP_ALTO        = 250,
    parameter int TEMP_INICIAL     = 215
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               habilitar,
    input  logic               adc_listo,
    input  logic               adc_valido,
    input  logic signed [10:0] adc_dato,
    output logic               adc_inicio,
    output logic signed [10:0] temp_registrado,
    output logic [2:0]         contador_fuera_rango,
    output logic               muestra_valida,
    output logic               error_adc,
    output logic [1:0]         estado_ctrl
);

    localparam int PW = $clog2(PERIODO_MUESTREO);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] RECARGA  = PW'(PERIODO_MUESTREO - 1);
    localparam logic [TW-1:0] T_ULTIMO = TW'(TIMEOUT - 1);
    localparam logic signed [10:0] BAJO    = 11'(TEMP_BAJO);
    localparam logic signed [10:0] ALTO    = 11'(TEMP_ALTO);
    localparam logic signed [10:0] INICIAL = 11'(TEMP_INICIAL);

    typedef enum logic [1:0] {
        ESPERA    = 2'b00,
        SOLICITA  = 2'b01,
        CONVIERTE = 2'b10,
        ACTUALIZA = 2'b11
    } estado_t;

    estado_t       estado;
    logic [PW-1:0] temporizador;
    logic [TW-1:0] cuenta_to;
    logic          fuera_rango;

    // Both bounds are inclusive; the compare is signed so negative readings count as low.
    assign fuera_rango = (adc_dato < BAJO) || (adc_dato > ALTO);
    assign estado_ctrl = estado;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            estado               <= ESPERA;
            temporizador         <= RECARGA;
            cuenta_to            <= '0;
            adc_inicio           <= 1'b0;
            temp_registrado      <= INICIAL;
            contador_fuera_rango <= 3'd0;
            muestra_valida       <= 1'b0;
            error_adc            <= 1'b0;
        end else begin
            muestra_valida <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (!habilitar) begin
                        temporizador <= RECARGA;
                    end else if (temporizador == '0) begin
                        estado     <= SOLICITA;
                        adc_inicio <= 1'b1;
                        cuenta_to  <= '0;
                    end else begin
                        temporizador <= temporizador - PW'(1);
                    end
                end
                SOLICITA: begin
                    if (cuenta_to == T_ULTIMO) begin
                        estado       <= ESPERA;
                        adc_inicio   <= 1'b0;
                        error_adc    <= 1'b1;
                        temporizador <= RECARGA;
                    end else begin
                        cuenta_to <= cuenta_to + TW'(1);
                        if (adc_listo) begin
                            estado     <= CONVIERTE;
                            adc_inicio <= 1'b0;
                        end
                    end
                end
                CONVIERTE: begin
                    // A result on the last allowed cycle still beats the timeout.
                    if (adc_valido) begin
                        estado          <= ACTUALIZA;
                        temp_registrado <= adc_dato;
                        muestra_valida  <= 1'b1;
                        error_adc       <= 1'b0;
                        if (!fuera_rango)
                            contador_fuera_rango <= 3'd0;
                        else if (contador_fuera_rango != 3'd7)
                            contador_fuera_rango <= contador_fuera_rango + 3'd1;
                    end else if (cuenta_to == T_ULTIMO) begin
                        estado       <= ESPERA;
                        error_adc    <= 1'b1;
                        temporizador <= RECARGA;
                    end else begin
                        cuenta_to <= cuenta_to + TW'(1);
                    end
                end
                ACTUALIZA: begin
                    estado       <= ESPERA;
                    temporizador <= RECARGA;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_control_muestreo.sv
// Directed bench for control_muestreo with a short period (8) and timeout (16);
// every muestra_valida pulse is matched against a queue of hand-computed samples.
module tb_control_muestreo;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               habilitar;
    logic               adc_listo;
    logic               adc_valido;
    logic signed [10:0] adc_dato;
    logic               adc_inicio;
    logic signed [10:0] temp_registrado;
    logic [2:0]         contador_fuera_rango;
    logic               muestra_valida;
    logic               error_adc;
    logic [1:0]         estado_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0]        exp_q[$];
    logic [13:0]        sb_e;
    logic signed [10:0] sb_t;

    typedef struct {
        int dato;
        int cont;
    } vec_t;

    control_muestreo #(
        .PERIODO_MUESTREO(8),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .habilitar(habilitar),
        .adc_listo(adc_listo),
        .adc_valido(adc_valido),
        .adc_dato(adc_dato),
        .adc_inicio(adc_inicio),
        .temp_registrado(temp_registrado),
        .contador_fuera_rango(contador_fuera_rango),
        .muestra_valida(muestra_valida),
        .error_adc(error_adc),
        .estado_ctrl(estado_ctrl)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each update pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (arst_n && muestra_valida) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_pulse: muestra_valida=1 with no sample expected (t=%0t)", $time);
            end else begin
                sb_e = exp_q.pop_front();
                sb_t = sb_e[13:3];
                check("sb_temp", int'(temp_registrado), int'(sb_t));
                check("sb_cont", int'(contador_fuera_rango), int'(sb_e[2:0]));
                check("sb_error_clear", int'(error_adc), 0);
                check("sb_state", int'(estado_ctrl), 3);
            end
        end
    end

    task automatic wait_inicio();
        int n = 0;
        while (!adc_inicio && n < 100) begin
            tick();
            n++;
        end
        check("wait_inicio", int'(adc_inicio), 1);
    endtask

    task automatic handshake();
        tick();
        check("hs_state", int'(estado_ctrl), 2);
        check("hs_inicio_low", int'(adc_inicio), 0);
    endtask

    task automatic convert(input int dato, input int cont, input int delay);
        repeat (delay) tick();
        adc_valido = 1'b1;
        adc_dato   = 11'(dato);
        exp_q.push_back({11'(dato), 3'(cont)});
        tick();
        adc_valido = 1'b0;
        tick();
        check("cont_hold", int'(contador_fuera_rango), cont);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_temp"}, int'(temp_registrado), 215);
        check({tag, "_cont"}, int'(contador_fuera_rango), 0);
        check({tag, "_state"}, int'(estado_ctrl), 0);
        check({tag, "_inicio"}, int'(adc_inicio), 0);
        check({tag, "_error"}, int'(error_adc), 0);
        check({tag, "_pulse"}, int'(muestra_valida), 0);
    endtask

    initial begin
        vec_t vec[$];
        int   seen;
        vec = '{'{170, 1}, '{100, 2}, '{260, 3}, '{300, 4}, '{120, 5}, '{90, 6},
                '{80, 7},  '{95, 7},  '{180, 0}, '{250, 0}, '{251, 1}, '{-5, 2},
                '{215, 0}, '{179, 1}};

        // Reset
        arst_n     = 1'b0;
        habilitar  = 1'b1;
        adc_listo  = 1'b1;
        adc_valido = 1'b0;
        adc_dato   = '0;
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        check_reset_values("rst");

        // Nominal sample: 8 ESPERA cycles, one-cycle request, capture of 200
        repeat (7) tick();
        check("nom_inicio_early", int'(adc_inicio), 0);
        tick();
        check("nom_inicio", int'(adc_inicio), 1);
        check("nom_state_sol", int'(estado_ctrl), 1);
        handshake();
        convert(200, 0, 2);

        // Persistence table
        foreach (vec[i]) begin
            wait_inicio();
            handshake();
            convert(vec[i].dato, vec[i].cont, i % 3);
        end

        // Handshake stall
        adc_listo = 1'b0;
        wait_inicio();
        repeat (5) begin
            tick();
            check("stall_inicio", int'(adc_inicio), 1);
            check("stall_state", int'(estado_ctrl), 1);
        end
        adc_listo = 1'b1;
        handshake();
        convert(220, 0, 1);

        // Timeout: no result for 16 cycles
        wait_inicio();
        repeat (15) tick();
        check("to_edge_state", int'(estado_ctrl), 2);
        check("to_edge_error", int'(error_adc), 0);
        tick();
        check("to_state", int'(estado_ctrl), 0);
        check("to_error", int'(error_adc), 1);
        check("to_inicio", int'(adc_inicio), 0);
        check("to_temp", int'(temp_registrado), 220);
        check("to_cont", int'(contador_fuera_rango), 0);

        // Result on the last allowed cycle wins and clears the error
        wait_inicio();
        check("error_sticky", int'(error_adc), 1);
        handshake();
        convert(300, 1, 14);
        check("error_cleared", int'(error_adc), 0);

        // Enable held low in ESPERA
        habilitar = 1'b0;
        seen = 0;
        repeat (20) begin
            tick();
            if (adc_inicio || estado_ctrl != 2'b00) seen++;
        end
        check("disabled_idle", seen, 0);
        habilitar = 1'b1;
        repeat (7) tick();
        check("reen_inicio_early", int'(adc_inicio), 0);
        tick();
        check("reen_inicio", int'(adc_inicio), 1);

        // Enable dropped during CONVIERTE: sample completes, then idle
        handshake();
        habilitar = 1'b0;
        convert(240, 0, 1);
        seen = 0;
        repeat (20) begin
            tick();
            if (adc_inicio || estado_ctrl != 2'b00) seen++;
        end
        check("drop_idle", seen, 0);

        // Stray adc_valido in ESPERA
        adc_valido = 1'b1;
        adc_dato   = 11'sd100;
        tick();
        adc_valido = 1'b0;
        tick();
        check("stray_temp", int'(temp_registrado), 240);
        check("stray_cont", int'(contador_fuera_rango), 0);

        // Reset in the middle of a conversion
        habilitar = 1'b1;
        wait_inicio();
        handshake();
        convert(400, 1, 0);
        wait_inicio();
        handshake();
        arst_n = 1'b0;
        #1;
        check_reset_values("arst");
        repeat (2) tick();
        arst_n     = 1'b1;
        adc_valido = 1'b1;
        adc_dato   = 11'sd50;
        tick();
        adc_valido = 1'b0;
        tick();
        check("post_rst_temp", int'(temp_registrado), 215);
        check("post_rst_state", int'(estado_ctrl), 0);

        check("sb_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_muestreo.md
Name: control_muestreo

Overview:
- Periodic acquisition sequencer for the temperature monitor.
- Schedules conversions on the shared ADC through a start/ready/valid handshake and registers each valid sample as temp_registrado.
- Maintains the out-of-range persistence counter contador_fuera_rango.
- Both outputs feed the temperature-state FSM directly. The block owns all sampling timing, timeout detection and counter semantics.

Parameters:
- PERIODO_MUESTREO, 1000: cycles spent in ESPERA between end of one transaction and next ADC request (min 2).
- TIMEOUT, 64: max cycles allowed from SOLICITA entry to adc_valido before abort (min 2).
- TEMP_BAJO, 180: lower in-range limit, inclusive.
- TEMP_ALTO, 250: upper in-range limit, inclusive.
- TEMP_INICIAL, 215: reset value of temp_registrado (in range).

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- habilitar  in  1  1 = periodic sampling enabled.
- adc_listo  in  1  ADC ready to accept a start.
- adc_valido  in  1  ADC conversion result valid, single-cycle pulse.
- adc_dato  in  11 signed  scaled temperature from ADC, sampled when adc_valido=1.
- adc_inicio  out  1  conversion request, registered.
- temp_registrado  out  11 signed  last accepted temperature.
- contador_fuera_rango  out  3  consecutive out-of-range samples, saturating at 7.
- muestra_valida  out  1  one-cycle pulse when temp_registrado/contador update.
- error_adc  out  1  sticky timeout flag.
- estado_ctrl  out  2  FSM state: ESPERA=00, SOLICITA=01, CONVIERTE=10, ACTUALIZA=11.

Behaviour:
- Reset (async, arst_n=0) values:
  - estado ESPERA, adc_inicio 0, temp_registrado TEMP_INICIAL, contador_fuera_rango 0, muestra_valida 0, error_adc 0.
  - Period timer loaded to PERIODO_MUESTREO-1; timeout counter 0.
  - Reset mid-transaction aborts immediately; ADC result arriving after reset release is ignored (FSM is in ESPERA).
- ESPERA:
  - Timer decrements each cycle while habilitar=1.
  - habilitar=0 holds the timer reloaded at PERIODO_MUESTREO-1.
  - Timer==0 with habilitar=1 -> SOLICITA next cycle. adc_inicio=1 is registered alongside the state change.
  - Timer reloads on every ESPERA entry.
- SOLICITA:
  - adc_inicio held 1 until a cycle with adc_listo=1. That cycle is the handshake -> CONVIERTE; adc_inicio=0 next cycle.
  - adc_listo already 1 on the first SOLICITA cycle -> handshake in that cycle.
- CONVIERTE:
  - adc_valido=1 -> on that edge temp_registrado<=adc_dato and the contador rule is applied -> ACTUALIZA.
  - adc_valido during ESPERA/SOLICITA/ACTUALIZA is ignored.
- ACTUALIZA:
  - Exactly one cycle with muestra_valida=1 and error_adc cleared -> ESPERA.
  - New values are visible in the same cycle muestra_valida is high.
- Contador rule (signed compare of adc_dato):
  - adc_dato<TEMP_BAJO or adc_dato>TEMP_ALTO -> contador+1, saturating at 7, no wrap.
  - Otherwise -> 0.
  - A direction change (low to high) does not reset the counter; both directions count as out of range.
- Timeout:
  - Counter starts at 0 on SOLICITA entry and increments every cycle in SOLICITA/CONVIERTE.
  - Reaching TIMEOUT-1 without adc_valido -> next cycle ESPERA, adc_inicio=0, error_adc=1.
  - temp_registrado and contador unchanged; no muestra_valida pulse.
  - adc_valido in the same cycle the count hits TIMEOUT-1 wins: normal capture, no error.
- habilitar deasserted in SOLICITA/CONVIERTE/ACTUALIZA: the in-flight transaction completes or times out normally; the block then idles in ESPERA.
- Latency: handshake edge to muestra_valida is 1 cycle after adc_valido. Steady-state sample spacing is PERIODO_MUESTREO + SOLICITA/CONVIERTE duration + 1 cycles.

Test Plan:
- Reset check: arst_n=0 for 3 cycles, then release -> temp_registrado=215, contador=0, estado_ctrl=00, adc_inicio=0, error_adc=0. Assert arst_n=0 while in CONVIERTE -> immediate return to these values.
- Nominal sample, PERIODO_MUESTREO=8, adc_listo tied 1:
  - After 8 cycles in ESPERA: adc_inicio for 1 cycle.
  - adc_valido with adc_dato=200 three cycles later -> next cycle muestra_valida=1, temp_registrado=200, contador=0.
- Persistence: samples 170, 100, 260, 300, 120, 90, 80, 95 -> contador 1,2,3,4,5,6,7,7. A following sample of 180 -> contador=0. Samples 250 and 251 -> 0 then 1.
- Handshake stall: adc_listo=0 for 5 cycles after adc_inicio rises -> adc_inicio stays 1 throughout and drops the cycle after adc_listo=1. estado_ctrl goes 01->10.
- Timeout, TIMEOUT=16: no adc_valido -> after 16 cycles estado_ctrl=00, error_adc=1, temp_registrado unchanged, no pulse. Next successful sample clears error_adc.
- Enable/stray inputs:
  - habilitar=0 in ESPERA for 20 cycles -> no adc_inicio.
  - habilitar dropped during CONVIERTE -> sample still completes, then idle.
  - adc_valido pulsed in ESPERA -> ignored, no update.
